vga_line_pattern_loader: RTL and testbench

Parametrised line-fill engine feeding the VGA line FIFO. It is the successor to the fixed 8-bit, 1280-pixel test-strip writer. On each load request from the VGA timing side, it latches the requested line number and streams one full line of generated pixels into the FIFO write port. It adds selectable patterns, FIFO-full backpressure, busy/done status and request-overrun detection. The pixel source slot is later swapped for the SDRAM reader behind the same FIFO interface.

---
 rtl/vga_line_pattern_loader.sv | 148 ++++++++++++++
 tb/tb_vga_line_pattern_loader.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_line_pattern_loader.sv
// ---------------------------------------------------------------------------
// vga_line_pattern_loader
//   Line-fill engine for the VGA line FIFO. A load request latches the line
//   number, pattern mode and strip offset, then one full line of generated
//   pixels (H_PIXELS writes) is streamed into the FIFO write port, stalling
//   while the FIFO reports full.
//
// Ports
//   iCLK, iRST_N      clock, asynchronous active-low reset
//   iLINE, iMODE,     line number / pattern / strip offset, sampled with
//   iOFFSET           the request
//   iLOAD_REQ         request level; a line starts once it falls again
//   iWFULL            FIFO full (synchronous to iCLK)
//   iCLR_ERR          clears oOVERRUN
//   oWCLK             FIFO write clock (~iCLK)
//   oWDATA, oWEN      FIFO write data / enable
//   oBUSY             line armed or in progress
//   oDONE             one-cycle pulse after the last pixel
//   oOVERRUN          sticky: new request edge while a line was running
// ---------------------------------------------------------------------------
module vga_line_pattern_loader #(
    parameter int DATA_W   = 8,
    parameter int H_PIXELS = 1280,
    parameter int LINE_W   = 13,
    parameter int STRIP_H  = 100,
    parameter int SQ_LOG2  = 4
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic [LINE_W-1:0] iLINE,
    input  logic              iLOAD_REQ,
    input  logic [1:0]        iMODE,
    input  logic [LINE_W-1:0] iOFFSET,
    input  logic              iWFULL,
    input  logic              iCLR_ERR,
    output logic              oWCLK,
    output logic [DATA_W-1:0] oWDATA,
    output logic              oWEN,
    output logic              oBUSY,
    output logic              oDONE,
    output logic              oOVERRUN
);

    localparam int CNT_W = $clog2(H_PIXELS);
    // Strip arithmetic carries one extra bit so offset+STRIP_H never wraps.
    localparam int EXT_W = LINE_W + 1;
    localparam int CMP_W = (EXT_W > CNT_W) ? EXT_W : CNT_W;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(H_PIXELS - 1);
    localparam logic [EXT_W-1:0] STRIP = EXT_W'(STRIP_H);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_LOAD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [LINE_W-1:0] line_q, off_q;
    logic [1:0]        mode_q;
    logic              req_q;
    logic              req_rise;

    assign oWCLK    = ~iCLK;
    assign req_rise = iLOAD_REQ & ~req_q;

    // ---------------- FSM ----------------
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        oWEN      = 1'b0;
        oBUSY     = 1'b0;
        oDONE     = 1'b0;
        case (state)
            S_IDLE: if (iLOAD_REQ) state_nxt = S_ARM;
            S_ARM: begin
                oBUSY = 1'b1;
                // The line only starts once the request level is released.
                if (!iLOAD_REQ) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                oBUSY = 1'b1;
                oWEN  = ~iWFULL;
                if (!iWFULL && cnt == LAST) state_nxt = S_DONE;
            end
            S_DONE: begin
                oDONE     = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- request latch, pixel counter, overrun ----------------
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            cnt      <= '0;
            line_q   <= '0;
            off_q    <= '0;
            mode_q   <= '0;
            req_q    <= 1'b0;
            oOVERRUN <= 1'b0;
        end else begin
            req_q <= iLOAD_REQ;
            if (state == S_IDLE && iLOAD_REQ) begin
                line_q <= iLINE;
                off_q  <= iOFFSET;
                mode_q <= iMODE;
                cnt    <= '0;
            end else if (oWEN) begin
                cnt <= cnt + 1'b1;
            end
            // A set in the same cycle as a clear must not be lost.
            if (req_rise && (state == S_LOAD || state == S_DONE))
                oOVERRUN <= 1'b1;
            else if (iCLR_ERR)
                oOVERRUN <= 1'b0;
        end
    end

    // ---------------- pattern generator ----------------
    logic [EXT_W-1:0]  line_e, off_e, diff;
    logic              in_strip;
    logic [DATA_W-1:0] pix;

    assign line_e   = {1'b0, line_q};
    assign off_e    = {1'b0, off_q};
    assign diff     = line_e - off_e;
    assign in_strip = (line_e >= off_e) && (line_e < off_e + STRIP);

    always_comb begin
        pix = '0;
        case (mode_q)
            2'd1: if (in_strip && CMP_W'(cnt) >= CMP_W'(diff)) pix = '1;
            2'd2: pix = DATA_W'(cnt);
            2'd3: if (cnt[SQ_LOG2] ^ line_q[SQ_LOG2]) pix = '1;
            default: pix = '0;
        endcase
    end

    assign oWDATA = (state == S_LOAD) ? pix : '0;

endmodule

// File: tb/tb_vga_line_pattern_loader.sv
// ---------------------------------------------------------------------------
// tb_vga_line_pattern_loader
//   Scoreboard bench: each launched line pushes its H_PIXELS expected pixels
//   into a queue; a negedge monitor pops and compares on every FIFO write.
// ---------------------------------------------------------------------------
module tb_vga_line_pattern_loader;

    localparam int DATA_W   = 8;
    localparam int H_PIXELS = 1280;
    localparam int LINE_W   = 13;
    localparam int STRIP_H  = 100;
    localparam int SQ_LOG2  = 4;
    localparam int LIMIT    = 10000;

    logic              iCLK = 1'b0;
    logic              iRST_N;
    logic [LINE_W-1:0] iLINE;
    logic              iLOAD_REQ;
    logic [1:0]        iMODE;
    logic [LINE_W-1:0] iOFFSET;
    logic              iWFULL;
    logic              iCLR_ERR;
    logic              oWCLK;
    logic [DATA_W-1:0] oWDATA;
    logic              oWEN, oBUSY, oDONE, oOVERRUN;

    vga_line_pattern_loader #(
        .DATA_W(DATA_W), .H_PIXELS(H_PIXELS), .LINE_W(LINE_W),
        .STRIP_H(STRIP_H), .SQ_LOG2(SQ_LOG2)
    ) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iLINE(iLINE), .iLOAD_REQ(iLOAD_REQ),
        .iMODE(iMODE), .iOFFSET(iOFFSET), .iWFULL(iWFULL), .iCLR_ERR(iCLR_ERR),
        .oWCLK(oWCLK), .oWDATA(oWDATA), .oWEN(oWEN), .oBUSY(oBUSY),
        .oDONE(oDONE), .oOVERRUN(oOVERRUN)
    );

    always #5 iCLK = ~iCLK;

    int   n_chk = 0;
    int   n_err = 0;
    int   wr_cnt = 0;
    logic rand_full = 1'b0;
    logic [7:0] sb_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Independent reference for one pixel.
    function automatic logic [7:0] ref_pix(input int line, input int mode, input int off, input int x);
        case (mode)
            1: if (line >= off && line < off + STRIP_H && x >= line - off) return 8'hFF;
               else return 8'h00;
            2: return 8'(x % 256);
            3: return ((((x / 16) % 2) ^ ((line / 16) % 2)) != 0) ? 8'hFF : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    // FIFO-full driver
    initial begin
        iWFULL = 1'b0;
        forever begin
            @(posedge iCLK); #1;
            iWFULL = rand_full ? ($urandom_range(0, 2) == 0) : 1'b0;
        end
    end

    // Write monitor / scoreboard consumer
    always @(negedge iCLK) begin
        if (iRST_N && oWEN) begin
            chk("wen_while_full", {31'b0, iWFULL}, 32'd0);
            if (sb_q.size() == 0) chk("extra_write", 32'd1, 32'd0);
            else                  chk("wdata", {24'b0, oWDATA}, {24'b0, sb_q.pop_front()});
            wr_cnt++;
        end
    end

    // Request a line: push expectations, hold the request, scramble inputs
    // once it drops, then check the ARM cycle and the first LOAD cycle.
    task automatic launch(input int line, input int mode, input int off, input int hold);
        for (int x = 0; x < H_PIXELS; x++) sb_q.push_back(ref_pix(line, mode, off, x));
        @(posedge iCLK); #1;
        iLINE = LINE_W'(line); iMODE = 2'(mode); iOFFSET = LINE_W'(off);
        iLOAD_REQ = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge iCLK); #1;
            chk("wen_while_req", {31'b0, oWEN}, 32'd0);
            @(posedge iCLK); #1;
        end
        iLOAD_REQ = 1'b0;
        iLINE = LINE_W'($urandom); iMODE = 2'($urandom); iOFFSET = LINE_W'($urandom);
        @(negedge iCLK); #1;
        chk("arm_wen", {31'b0, oWEN}, 32'd0);
        chk("arm_busy", {31'b0, oBUSY}, 32'd1);
        @(negedge iCLK); #1;
        chk("first_write", {31'b0, oWEN}, {31'b0, ~iWFULL});
    endtask

    task automatic finish_line(input int wr0);
        int n = 0;
        while (!oDONE && n < LIMIT) begin
            @(negedge iCLK); #1;
            n++;
        end
        chk("done_seen", {31'b0, oDONE}, 32'd1);
        chk("wr_count", 32'(wr_cnt - wr0), 32'(H_PIXELS));
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        @(negedge iCLK); #1;
        chk("done_one_cycle", {31'b0, oDONE}, 32'd0);
        chk("busy_after", {31'b0, oBUSY}, 32'd0);
    endtask

    task automatic run_line(input int line, input int mode, input int off, input int hold);
        int wr0 = wr_cnt;
        launch(line, mode, off, hold);
        finish_line(wr0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_wen"},  {31'b0, oWEN},  32'd0);
        chk({tag, "_busy"}, {31'b0, oBUSY}, 32'd0);
        chk({tag, "_done"}, {31'b0, oDONE}, 32'd0);
        chk({tag, "_ovr"},  {31'b0, oOVERRUN}, 32'd0);
        chk({tag, "_data"}, {24'b0, oWDATA}, 32'd0);
    endtask

    initial begin
        int wr0;
        int n;
        iRST_N = 1'b0; iLINE = '0; iLOAD_REQ = 1'b0; iMODE = '0;
        iOFFSET = '0; iCLR_ERR = 1'b0;
        repeat (3) @(negedge iCLK);
        #1 chk_reset_outs("rst");
        @(posedge iCLK); #2 iRST_N = 1'b1;

        // Ramp, checker, strip boundaries, black
        run_line(0, 2, 0, 1);
        run_line(16, 3, 0, 1);
        run_line(37, 3, 0, 1);
        run_line(15, 1, 10, 1);
        run_line(110, 1, 10, 1);
        run_line(109, 1, 10, 1);
        run_line(9, 1, 10, 1);
        run_line(5, 1, 8190, 1);
        run_line(200, 0, 0, 1);

        // Backpressure
        rand_full = 1'b1;
        run_line(3, 2, 0, 1);
        run_line(48, 3, 0, 2);
        rand_full = 1'b0;

        // Request held for 20 cycles
        run_line(1, 2, 0, 20);

        // Overrun mid-line, set beats clear, sticky to line end, then clear
        wr0 = wr_cnt;
        launch(20, 3, 0, 1);
        repeat (100) @(posedge iCLK);
        #1 iLOAD_REQ = 1'b1;
        @(posedge iCLK); #1 iLOAD_REQ = 1'b0;
        @(negedge iCLK); #1 chk("ovr_set", {31'b0, oOVERRUN}, 32'd1);
        @(posedge iCLK); #1 iLOAD_REQ = 1'b1; iCLR_ERR = 1'b1;
        @(posedge iCLK); #1 iLOAD_REQ = 1'b0; iCLR_ERR = 1'b0;
        @(negedge iCLK); #1 chk("ovr_set_wins", {31'b0, oOVERRUN}, 32'd1);
        finish_line(wr0);
        chk("ovr_sticky", {31'b0, oOVERRUN}, 32'd1);
        @(posedge iCLK); #1 iCLR_ERR = 1'b1;
        @(posedge iCLK); #1 iCLR_ERR = 1'b0;
        @(negedge iCLK); #1 chk("ovr_clr", {31'b0, oOVERRUN}, 32'd0);

        // Reset at pixel 600 aborts the line
        wr0 = wr_cnt;
        launch(0, 2, 0, 1);
        n = 0;
        while (wr_cnt - wr0 < 600 && n < LIMIT) begin
            @(negedge iCLK); #1;
            n++;
        end
        chk("reach_600", 32'(wr_cnt - wr0), 32'd600);
        iRST_N = 1'b0;
        #1 chk_reset_outs("abort");
        wr0 = wr_cnt;
        repeat (5) @(negedge iCLK);
        #1 chk("abort_no_writes", 32'(wr_cnt - wr0), 32'd0);
        sb_q.delete();
        @(posedge iCLK); #2 iRST_N = 1'b1;
        run_line(40, 2, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
